// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
//   Interrupt front end for an external 8-to-3 priority encoder.
//   - Latches request lines into a pending register. EDGE_MODE=1 latches rising
//     edges; EDGE_MODE=0 sets the bit every cycle the line is high.
//   - Feeds the unmasked pending lines to the encoder.
//   - Offers the encoder's winner as a single vector over a valid/ack handshake.
//   - Blocks any further vector until end-of-interrupt. There is no nesting.
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   irq_in, irq_mask    request lines; mask (1 = masked, still kept pending)
//   enc_i, enc_ei       to encoder I / EI
//   enc_y, enc_gs       from encoder Y / GS
//   irq_valid, irq_id   offered vector; irq_id is frozen while valid
//   irq_ack, eoi        consumer accept / end-of-interrupt pulse
//   pend_o, busy        raw pending register; high while the vector is in service
module irq_pending_ctrl #(
    parameter int N         = 8,
    parameter int IDW       = 3,
    parameter int EDGE_MODE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   irq_in,
    input  logic [N-1:0]   irq_mask,
    output logic [N-1:0]   enc_i,
    output logic           enc_ei,
    input  logic [IDW-1:0] enc_y,
    input  logic           enc_gs,
    output logic           irq_valid,
    output logic [IDW-1:0] irq_id,
    input  logic           irq_ack,
    input  logic           eoi,
    output logic [N-1:0]   pend_o,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SERV = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   prev_q;
    logic [N-1:0]   set_v, clr_v;
    logic           valid_q, valid_d;
    logic [IDW-1:0] id_q, id_d;
    logic           ack_acc;

    assign ack_acc = valid_q & irq_ack;

    // A new request on a line wins over the same-cycle clear caused by its ack.
    // This keeps a back-to-back edge from being lost.
    always_comb begin
        set_v = (EDGE_MODE != 0) ? (irq_in & ~prev_q) : irq_in;
        clr_v = '0;
        if (ack_acc) clr_v[id_q] = 1'b1;
        pend_d = set_v | (pend_q & ~clr_v);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            prev_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            prev_q  <= irq_in;
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    // The encoder is only enabled in IDLE, so enc_gs is meaningful only there.
    // Once a vector is captured, later mask or pend changes cannot alter it.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        enc_ei  = 1'b0;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                enc_ei = 1'b1;
                if (enc_gs) begin
                    id_d    = enc_y;
                    valid_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (irq_ack) begin
                    valid_d = 1'b0;
                    state_d = S_SERV;
                end
            end
            S_SERV: begin
                busy = 1'b1;
                if (eoi) state_d = S_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign enc_i     = pend_q & ~irq_mask;
    assign pend_o    = pend_q;
    assign irq_valid = valid_q;
    assign irq_id    = id_q;

endmodule
